// File: rtl/audio_fifo_i2s_pkg.sv
// Shared types and helpers for the audio FIFO / I2S serialiser.
package audio_fifo_i2s_pkg;

  // Serialiser sequencing: idle, waiting for the FIFO to fill, playing, finishing the last frame
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } i2s_state_t;

  // Widest word and sample the saturation helper handles
  localparam int MAX_DATA_W   = 64;
  localparam int MAX_SAMPLE_W = 32;

  // Clamp a signed word to a sampleW-bit sample taken from bit 'shift' upwards.
  // The word fits when every bit from the sample MSB up to the word MSB is a copy
  // of the sign; otherwise the result is the most negative or most positive sample.
  // Only the low sampleW bits of the result are meaningful.
  function automatic logic [MAX_SAMPLE_W-1:0] sat_sample(
    input logic [MAX_DATA_W-1:0] word,
    input int                    dataW,
    input int                    sampleW,
    input int                    shift
  );
    logic [MAX_DATA_W-1:0]   upper;
    logic [MAX_DATA_W-1:0]   mask;
    logic [MAX_DATA_W-1:0]   shifted;
    logic [MAX_SAMPLE_W-1:0] maxPos;
    logic                    signBit;
    logic                    allSame;
    int                      nUpper;
    nUpper  = dataW - shift - sampleW + 1;
    shifted = word >> shift;
    upper   = word >> (shift + sampleW - 1);
    mask    = (64'd1 << nUpper) - 64'd1;
    allSame = ((upper & mask) == '0) || ((upper & mask) == mask);
    signBit = |(word & (64'd1 << (dataW - 1)));
    maxPos  = 32'd1 << (sampleW - 1);
    if (allSame) begin
      return shifted[MAX_SAMPLE_W-1:0];
    end else if (signBit) begin
      return maxPos;
    end else begin
      return maxPos - 32'd1;
    end
  endfunction

endpackage

// File: rtl/audio_fifo_i2s_sample_fifo.sv
// Synchronous sample FIFO with registered full flag, occupancy count and a drop strobe.
module audio_fifo_i2s_sample_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wrData,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rdData,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_wrDrop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_countNext;
  logic              r_full;
  logic              w_doPush;
  logic              w_doPop;

  assign w_doPush = i_push && !r_full;
  assign w_doPop  = i_pop && (r_count != '0);
  assign o_wrDrop = i_push && r_full;

  // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged
  always_comb begin
    w_countNext = r_count;
    case ({w_doPush, w_doPop})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= w_countNext;
      r_full  <= (w_countNext == (AW+1)'(DEPTH));
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wrData;
  end

  assign o_rdData = r_mem[r_rdPtr];
  assign o_full   = r_full;
  assign o_empty  = (r_count == '0);
  assign o_level  = r_count;

endmodule

// File: rtl/audio_fifo_i2s.sv
// Buffers mixed tone words and plays them as a mono I2S master (same sample left and right).
module audio_fifo_i2s
  import audio_fifo_i2s_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 16,
  parameter int SHIFT    = 0,
  parameter int BCLK_DIV = 16,
  parameter int PRIME    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_ld_fifo,
  input  logic [DATA_W-1:0]      i_tone,
  input  logic                   i_clr_flags,
  output logic                   o_fifo_full,
  output logic [$clog2(DEPTH):0] o_fifo_level,
  output logic                   o_overflow,
  output logic                   o_underrun,
  output logic                   o_bclk,
  output logic                   o_lrclk,
  output logic                   o_dacdat
);

  localparam int LW         = $clog2(DEPTH) + 1;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int FRAME_BITS = 2 * SAMPLE_W;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_HALF  = BIT_W'(SAMPLE_W);
  localparam logic [BIT_W-1:0] BIT_MSB   = BIT_W'(1);
  localparam logic [LW-1:0]    PRIME_LVL = LW'(PRIME);

  i2s_state_t              r_state;
  i2s_state_t              w_stateNext;
  logic [DIV_W-1:0]        r_div;
  logic [BIT_W-1:0]        r_bit;
  logic [BIT_W-1:0]        w_bitNext;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_dacdat;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [SAMPLE_W-1:0]     r_sample;
  logic [SAMPLE_W-1:0]     w_sat;
  logic                    r_lastPeriod;
  logic                    r_overflow;
  logic                    r_underrun;
  logic                    w_running;
  logic                    w_fall;
  logic                    w_pop;
  logic [DATA_W-1:0]       w_rdData;
  logic                    w_full;
  logic                    w_empty;
  logic [LW-1:0]           w_level;
  logic                    w_wrDrop;

  audio_fifo_i2s_sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (i_ld_fifo),
    .i_wrData (i_tone),
    .i_pop    (w_pop),
    .o_rdData (w_rdData),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level),
    .o_wrDrop (w_wrDrop)
  );

  assign w_running = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_fall    = w_running && r_bclk && (r_div == DIV_LAST);
  assign w_bitNext = (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
  assign w_sat     = SAMPLE_W'(sat_sample(MAX_DATA_W'(w_rdData), DATA_W, SAMPLE_W, SHIFT));

  // Next state and the frame-start pop (on entering RUN and at every fall into bit 0 while playing)
  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) w_stateNext = ST_PRIME;
      end
      ST_PRIME: begin
        if (!i_enable) begin
          w_stateNext = ST_IDLE;
        end else if (w_level >= PRIME_LVL) begin
          w_stateNext = ST_RUN;
          w_pop       = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_fall && (w_bitNext == '0)) w_pop = 1'b1;
        if (!i_enable) w_stateNext = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_fall && (r_bit == '0) && r_lastPeriod) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_stateNext;
  end

  // Bit-clock divider, frame bit counter and serial shifter; all held at zero when not playing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div        <= '0;
      r_bit        <= '0;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_dacdat     <= 1'b0;
      r_shift      <= '0;
      r_lastPeriod <= 1'b0;
    end else if (!w_running || (w_stateNext == ST_IDLE)) begin
      r_div        <= '0;
      r_bit        <= '0;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_dacdat     <= 1'b0;
      r_shift      <= '0;
      r_lastPeriod <= 1'b0;
    end else begin
      if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fall) begin
        r_bit   <= w_bitNext;
        r_lrclk <= (w_bitNext >= BIT_HALF);
        if (w_bitNext == BIT_MSB) begin
          r_shift  <= {r_sample, r_sample} << 1;
          r_dacdat <= r_sample[SAMPLE_W-1];
        end else begin
          r_shift  <= r_shift << 1;
          r_dacdat <= r_shift[FRAME_BITS-1];
        end
        if ((r_state == ST_DRAIN) && (w_bitNext == '0)) r_lastPeriod <= 1'b1;
      end
    end
  end

  // Sample latched at the frame-start pop, zero when the FIFO was found empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_sample <= '0;
    else if (w_pop) r_sample <= w_empty ? '0 : w_sat;
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_wrDrop)         r_overflow <= 1'b1;
      else if (i_clr_flags) r_overflow <= 1'b0;
      if (w_pop && w_empty) r_underrun <= 1'b1;
      else if (i_clr_flags) r_underrun <= 1'b0;
    end
  end

  assign o_fifo_full  = w_full;
  assign o_fifo_level = w_level;
  assign o_overflow   = r_overflow;
  assign o_underrun   = r_underrun;
  assign o_bclk       = r_bclk;
  assign o_lrclk      = r_lrclk;
  assign o_dacdat     = r_dacdat;

endmodule

// File: tb/tb_audio_fifo_i2s.sv
// Directed, scoreboard-based bench for audio_fifo_i2s (DEPTH=4, BCLK_DIV=2, PRIME=2, SHIFT=0).
module tb_audio_fifo_i2s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        ldFifo;
  logic [31:0] tone;
  logic        clrFlags;
  logic        fifoFull;
  logic [2:0]  fifoLevel;
  logic        overflow;
  logic        underrun;
  logic        bclk;
  logic        lrclk;
  logic        dacdat;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          framesSeen = 0;
  int          cyc = 0;
  logic [15:0] expQ [$];

  audio_fifo_i2s #(
    .DEPTH    (4),
    .DATA_W   (32),
    .SAMPLE_W (16),
    .SHIFT    (0),
    .BCLK_DIV (2),
    .PRIME    (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_ld_fifo    (ldFifo),
    .i_tone       (tone),
    .i_clr_flags  (clrFlags),
    .o_fifo_full  (fifoFull),
    .o_fifo_level (fifoLevel),
    .o_overflow   (overflow),
    .o_underrun   (underrun),
    .o_bclk       (bclk),
    .o_lrclk      (lrclk),
    .o_dacdat     (dacdat)
  );

  // 10-time-unit system clock
  always #5 clk = ~clk;

  // Free-running cycle count used for period measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Expected sample for a 32-bit word with a 16-bit sample taken from bit 0
  function automatic logic [15:0] benchSat(input logic [31:0] w);
    if ((w[31:15] == 17'h1FFFF) || (w[31:15] == 17'h00000)) return w[15:0];
    else if (w[31]) return 16'h8000;
    else return 16'h7FFF;
  endfunction

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Push one word; the scoreboard keeps it only if a 4-deep FIFO has room
  task automatic applyStimulus(input logic [31:0] word);
    ldFifo = 1'b1;
    tone   = word;
    if (expQ.size() < 4) expQ.push_back(benchSat(word));
    @(negedge clk);
    ldFifo = 1'b0;
    tone   = '0;
  endtask

  // Bounded wait for an edge of BCLK (selLr=0) or LRCLK (selLr=1)
  task automatic waitEdge(input bit selLr, input bit wantRise, input int maxCyc, input string tag);
    logic prevV;
    logic curV;
    bit   seen;
    prevV = selLr ? lrclk : bclk;
    seen  = 1'b0;
    for (int n = 0; n < maxCyc && !seen; n++) begin
      @(negedge clk);
      curV = selLr ? lrclk : bclk;
      if (wantRise ? (curV && !prevV) : (!curV && prevV)) seen = 1'b1;
      prevV = curV;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  // Bounded wait until both clocks have been low long enough to mean the serialiser is idle
  task automatic waitIdle(input string tag);
    int quiet;
    quiet = 0;
    for (int n = 0; n < 600 && quiet < 6; n++) begin
      @(negedge clk);
      if (!bclk && !lrclk) quiet++;
      else quiet = 0;
    end
    checkOutput(tag, {31'd0, quiet >= 6}, 32'd1);
  endtask

  // Frame monitor: captures DACDAT on BCLK rises; a rise with LRCLK low after one with LRCLK high
  // is the right-channel LSB, at which point the last 32 bits are {left, right}
  initial begin : monitor
    logic        prevB;
    logic        prevLr;
    logic [31:0] bits;
    logic [15:0] expS;
    prevB  = 1'b0;
    prevLr = 1'b0;
    bits   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevB  = 1'b0;
        prevLr = 1'b0;
        bits   = '0;
      end else begin
        if (bclk && !prevB) begin
          bits = {bits[30:0], dacdat};
          if (!lrclk && prevLr) begin
            if (expQ.size() > 0) expS = expQ.pop_front();
            else expS = 16'h0000;
            checkOutput("frameLeft",  {16'h0, bits[31:16]}, {16'h0, expS});
            checkOutput("frameRight", {16'h0, bits[15:0]},  {16'h0, expS});
            framesSeen++;
          end
          prevLr = lrclk;
        end
        prevB = bclk;
      end
    end
  end

  // Directed sequence
  initial begin : stimulus
    int base;
    int t0;
    int toggles;
    logic prevB;

    rst_n    = 1'b0;
    enable   = 1'b0;
    ldFifo   = 1'b0;
    clrFlags = 1'b0;
    tone     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBclk",     32'(bclk),      32'd0);
    checkOutput("rstLrclk",    32'(lrclk),     32'd0);
    checkOutput("rstDacdat",   32'(dacdat),    32'd0);
    checkOutput("rstFull",     32'(fifoFull),  32'd0);
    checkOutput("rstLevel",    32'(fifoLevel), 32'd0);
    checkOutput("rstOverflow", 32'(overflow),  32'd0);
    checkOutput("rstUnderrun", 32'(underrun),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic playback, frame period and underrun");
    applyStimulus(32'h00001234);
    applyStimulus(32'hFFFFFF00);
    checkOutput("levelTwo", 32'(fifoLevel), 32'd2);
    base   = framesSeen;
    enable = 1'b1;
    waitEdge(1'b1, 1'b1, 400, "lrRiseA");
    t0 = cyc;
    waitEdge(1'b1, 1'b1, 400, "lrRiseB");
    checkOutput("lrclkPeriod", 32'(cyc - t0), 32'd128);
    for (int n = 0; n < 800 && framesSeen < base + 3; n++) @(negedge clk);
    checkOutput("threeFrames", {31'd0, framesSeen >= base + 3}, 32'd1);
    checkOutput("underrunSet", 32'(underrun), 32'd1);
    toggles = 0;
    prevB   = bclk;
    repeat (16) begin
      @(negedge clk);
      if (bclk != prevB) toggles++;
      prevB = bclk;
    end
    checkOutput("bclkTogglesInUnderrun", 32'(toggles), 32'd8);
    enable = 1'b0;
    waitIdle("idleAfterBasic");
    checkOutput("levelEmpty", 32'(fifoLevel), 32'd0);
    checkOutput("underrunSticky", 32'(underrun), 32'd1);
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0;
    checkOutput("underrunCleared", 32'(underrun), 32'd0);

    $display("[TB] fill to full and overflow while stopped");
    applyStimulus(32'hFFFE0000);
    applyStimulus(32'hFFFF8000);
    applyStimulus(32'h00012345);
    checkOutput("notFullAtThree", 32'(fifoFull), 32'd0);
    applyStimulus(32'h00000001);
    checkOutput("fullAtFour", 32'(fifoFull), 32'd1);
    checkOutput("levelFour", 32'(fifoLevel), 32'd4);
    checkOutput("noOverflowYet", 32'(overflow), 32'd0);
    applyStimulus(32'h00005555);
    checkOutput("overflowSet", 32'(overflow), 32'd1);
    checkOutput("levelStillFour", 32'(fifoLevel), 32'd4);
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0;
    checkOutput("overflowCleared", 32'(overflow), 32'd0);
    checkOutput("stillFull", 32'(fifoFull), 32'd1);

    $display("[TB] saturation frames, then stop at bit 5 of the third frame");
    base   = framesSeen;
    enable = 1'b1;
    waitEdge(1'b1, 1'b0, 400, "lrFallA");
    waitEdge(1'b1, 1'b0, 400, "lrFallB");
    repeat (5) waitEdge(1'b0, 1'b0, 20, "bclkFall");
    enable = 1'b0;
    waitIdle("idleAfterStop");
    checkOutput("framesBeforeStop", 32'(framesSeen - base), 32'd3);
    checkOutput("noExtraPop", 32'(fifoLevel), 32'd1);
    checkOutput("stopBclk", 32'(bclk), 32'd0);
    checkOutput("stopLrclk", 32'(lrclk), 32'd0);
    checkOutput("stopDacdat", 32'(dacdat), 32'd0);
    checkOutput("noUnderrun", 32'(underrun), 32'd0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(32'h00000ABC);
    checkOutput("levelBeforeReset", 32'(fifoLevel), 32'd2);
    base   = framesSeen;
    enable = 1'b1;
    waitEdge(1'b1, 1'b0, 400, "lrFallC");
    repeat (3) waitEdge(1'b0, 1'b0, 20, "bclkFallC");
    checkOutput("framesBeforeReset", 32'(framesSeen - base), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBclk",     32'(bclk),      32'd0);
    checkOutput("midRstLrclk",    32'(lrclk),     32'd0);
    checkOutput("midRstDacdat",   32'(dacdat),    32'd0);
    checkOutput("midRstFull",     32'(fifoFull),  32'd0);
    checkOutput("midRstLevel",    32'(fifoLevel), 32'd0);
    checkOutput("midRstOverflow", 32'(overflow),  32'd0);
    checkOutput("midRstUnderrun", 32'(underrun),  32'd0);
    expQ.delete();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
